// File: rtl/vpg_timing_gen.sv
// Video pattern generator: programmable sync/DE timing with colour bars, grey ramp, checkerboard and solid fill.
// Latency: every output is registered 2 clk after the counter state that produced it; cfg_pending 1 clk after cfg_load.
// Backpressure: none, free-running at the pixel clock; new timing is taken only at the frame boundary.
// Optional build: define VPG_SCROLL_EN to scroll patterns 0 and 2 by one pixel per frame.
module vpg_timing_gen #(
  parameter int COORD_W = 12,
  parameter int DATA_W  = 8,
  parameter int H_TOTAL = 2199,
  parameter int H_SYNC  = 43,
  parameter int H_START = 189,
  parameter int H_END   = 2109,
  parameter int V_TOTAL = 1124,
  parameter int V_SYNC  = 4,
  parameter int V_START = 40,
  parameter int V_END   = 1120
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_load,
  input  logic [COORD_W-1:0]    cfg_h_total,
  input  logic [COORD_W-1:0]    cfg_h_sync,
  input  logic [COORD_W-1:0]    cfg_h_start,
  input  logic [COORD_W-1:0]    cfg_h_end,
  input  logic [COORD_W-1:0]    cfg_v_total,
  input  logic [COORD_W-1:0]    cfg_v_sync,
  input  logic [COORD_W-1:0]    cfg_v_start,
  input  logic [COORD_W-1:0]    cfg_v_end,
  input  logic                  cfg_hs_neg,
  input  logic                  cfg_vs_neg,
  input  logic [1:0]            cfg_pattern,
  input  logic [3*DATA_W-1:0]   cfg_solid,
  output logic                  cfg_pending,
  output logic                  vid_hs,
  output logic                  vid_vs,
  output logic                  vid_de,
  output logic [DATA_W-1:0]     vid_r,
  output logic [DATA_W-1:0]     vid_g,
  output logic [DATA_W-1:0]     vid_b,
  output logic                  frame_start
);

  typedef struct packed {
    logic [COORD_W-1:0]  h_total;
    logic [COORD_W-1:0]  h_sync;
    logic [COORD_W-1:0]  h_start;
    logic [COORD_W-1:0]  h_end;
    logic [COORD_W-1:0]  v_total;
    logic [COORD_W-1:0]  v_sync;
    logic [COORD_W-1:0]  v_start;
    logic [COORD_W-1:0]  v_end;
    logic                hs_neg;
    logic                vs_neg;
    logic [1:0]          pattern;
    logic [3*DATA_W-1:0] solid;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    h_total: COORD_W'(H_TOTAL), h_sync: COORD_W'(H_SYNC),
    h_start: COORD_W'(H_START), h_end: COORD_W'(H_END),
    v_total: COORD_W'(V_TOTAL), v_sync: COORD_W'(V_SYNC),
    v_start: COORD_W'(V_START), v_end: COORD_W'(V_END),
    hs_neg: 1'b0, vs_neg: 1'b0, pattern: 2'd0, solid: '0};

  logic [COORD_W-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  cfg_t                act_q, act_d, shd_q, shd_d, cfg_in;
  logic                pending_q, pending_d;
  logic                h_wrap, v_wrap, frame_wrap;
`ifdef VPG_SCROLL_EN
  logic [COORD_W-1:0]  offset_q, offset_d;
`endif

  logic                s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_de_q, s1_de_d, s1_fs_q, s1_fs_d;
  logic [3*DATA_W-1:0] s1_rgb_q, s1_rgb_d;
  logic                vid_hs_q, vid_hs_d, vid_vs_q, vid_vs_d, vid_de_q, vid_de_d, vid_fs_q, vid_fs_d;
  logic [3*DATA_W-1:0] vid_rgb_q, vid_rgb_d;

  logic                hs_raw, vs_raw, de_raw;
  logic [COORD_W-1:0]  px_x, px_y, act_w, x_bar, x_chk;
  logic [2:0]          bar_idx;
  logic [DATA_W-1:0]   pr, pg, pb;
  logic                unused_bits;

  assign cfg_in = '{
    h_total: cfg_h_total, h_sync: cfg_h_sync, h_start: cfg_h_start, h_end: cfg_h_end,
    v_total: cfg_v_total, v_sync: cfg_v_sync, v_start: cfg_v_start, v_end: cfg_v_end,
    hs_neg: cfg_hs_neg, vs_neg: cfg_vs_neg, pattern: cfg_pattern, solid: cfg_solid};

  // Counter advance (>= wrap recovers from shrinking timing), shadow capture and frame-boundary apply
  always_comb begin
    h_wrap     = (h_cnt_q >= act_q.h_total);
    v_wrap     = (v_cnt_q >= act_q.v_total);
    frame_wrap = h_wrap && v_wrap;
    h_cnt_d    = h_wrap ? '0 : h_cnt_q + COORD_W'(1);
    v_cnt_d    = v_cnt_q;
    if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + COORD_W'(1);
    act_d      = act_q;
    shd_d      = shd_q;
    pending_d  = pending_q;
    if (frame_wrap) begin
      if (pending_q) act_d = shd_q;
      pending_d = 1'b0;
    end
    // A load on the apply cycle lands after the old shadow has been taken
    if (cfg_load) begin
      shd_d     = cfg_in;
      pending_d = 1'b1;
    end
`ifdef VPG_SCROLL_EN
    offset_d   = frame_wrap ? offset_q + COORD_W'(1) : offset_q;
`endif
  end

  // Raw sync/DE and pixel colour from the current counter state, then the two-stage output pipe
  always_comb begin
    hs_raw = (h_cnt_q <= act_q.h_sync);
    vs_raw = (v_cnt_q <= act_q.v_sync);
    de_raw = (h_cnt_q > act_q.h_start) && (h_cnt_q <= act_q.h_end) &&
             (v_cnt_q > act_q.v_start) && (v_cnt_q <= act_q.v_end);
    px_x   = h_cnt_q - act_q.h_start - COORD_W'(1);
    px_y   = v_cnt_q - act_q.v_start - COORD_W'(1);
    act_w  = act_q.h_end - act_q.h_start;
`ifdef VPG_SCROLL_EN
    x_bar  = COORD_W'(({1'b0, px_x} + {1'b0, offset_q}) % {1'b0, act_w});
    x_chk  = px_x + offset_q;
`else
    x_bar  = px_x;
    x_chk  = px_x;
`endif
    bar_idx = 3'({x_bar, 3'b000} / {3'b000, act_w});
    pr = '0;
    pg = '0;
    pb = '0;
    case (act_q.pattern)
      // Bar order white..black: red off for bars 2,3,6,7; green off for 4..7; blue off for odd bars
      2'd0: begin
        pr = {DATA_W{~bar_idx[1]}};
        pg = {DATA_W{~bar_idx[2]}};
        pb = {DATA_W{~bar_idx[0]}};
      end
      2'd1: begin
        pr = px_x[COORD_W-1 -: DATA_W];
        pg = pr;
        pb = pr;
      end
      2'd2: begin
        pr = {DATA_W{x_chk[5] ^ px_y[5]}};
        pg = pr;
        pb = pr;
      end
      default: {pr, pg, pb} = act_q.solid;
    endcase
    s1_hs_d   = hs_raw ^ act_q.hs_neg;
    s1_vs_d   = vs_raw ^ act_q.vs_neg;
    s1_de_d   = de_raw;
    s1_fs_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
    s1_rgb_d  = de_raw ? {pr, pg, pb} : '0;
    vid_hs_d  = s1_hs_q;
    vid_vs_d  = s1_vs_q;
    vid_de_d  = s1_de_q;
    vid_fs_d  = s1_fs_q;
    vid_rgb_d = s1_rgb_q;
  end

  assign unused_bits = ^{px_y[COORD_W-1:6], px_y[4:0], x_chk[COORD_W-1:6], x_chk[4:0]};

  // All state and output registers; reset restores parameter timing and drops any pending load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      act_q     <= CFG_RESET;
      shd_q     <= '0;
      pending_q <= 1'b0;
`ifdef VPG_SCROLL_EN
      offset_q  <= '0;
`endif
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_de_q   <= 1'b0;
      s1_fs_q   <= 1'b0;
      s1_rgb_q  <= '0;
      vid_hs_q  <= 1'b0;
      vid_vs_q  <= 1'b0;
      vid_de_q  <= 1'b0;
      vid_fs_q  <= 1'b0;
      vid_rgb_q <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      pending_q <= pending_d;
`ifdef VPG_SCROLL_EN
      offset_q  <= offset_d;
`endif
      s1_hs_q   <= s1_hs_d;
      s1_vs_q   <= s1_vs_d;
      s1_de_q   <= s1_de_d;
      s1_fs_q   <= s1_fs_d;
      s1_rgb_q  <= s1_rgb_d;
      vid_hs_q  <= vid_hs_d;
      vid_vs_q  <= vid_vs_d;
      vid_de_q  <= vid_de_d;
      vid_fs_q  <= vid_fs_d;
      vid_rgb_q <= vid_rgb_d;
    end
  end

  assign cfg_pending = pending_q;
  assign vid_hs      = vid_hs_q;
  assign vid_vs      = vid_vs_q;
  assign vid_de      = vid_de_q;
  assign frame_start = vid_fs_q;
  assign vid_r       = vid_rgb_q[3*DATA_W-1 -: DATA_W];
  assign vid_g       = vid_rgb_q[2*DATA_W-1 -: DATA_W];
  assign vid_b       = vid_rgb_q[DATA_W-1:0];

endmodule

// File: tb/tb_vpg_timing_gen.sv
// Randomized scoreboard bench for vpg_timing_gen with small reset timing (40x12 clk frame).
module tb_vpg_timing_gen;
  localparam int CW = 12;
  localparam int DW = 8;
  localparam int P_HT = 39, P_HS = 3, P_HST = 7, P_HEN = 35;
  localparam int P_VT = 11, P_VS = 1, P_VST = 2, P_VEN = 10;
`ifdef VPG_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cfg_load = 1'b0;
  logic [CW-1:0] cfg_h_total, cfg_h_sync, cfg_h_start, cfg_h_end;
  logic [CW-1:0] cfg_v_total, cfg_v_sync, cfg_v_start, cfg_v_end;
  logic cfg_hs_neg, cfg_vs_neg;
  logic [1:0] cfg_pattern;
  logic [3*DW-1:0] cfg_solid;
  logic cfg_pending, vid_hs, vid_vs, vid_de, frame_start;
  logic [DW-1:0] vid_r, vid_g, vid_b;

  vpg_timing_gen #(
    .COORD_W(CW), .DATA_W(DW),
    .H_TOTAL(P_HT), .H_SYNC(P_HS), .H_START(P_HST), .H_END(P_HEN),
    .V_TOTAL(P_VT), .V_SYNC(P_VS), .V_START(P_VST), .V_END(P_VEN)
  ) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load),
    .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync), .cfg_h_start(cfg_h_start), .cfg_h_end(cfg_h_end),
    .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync), .cfg_v_start(cfg_v_start), .cfg_v_end(cfg_v_end),
    .cfg_hs_neg(cfg_hs_neg), .cfg_vs_neg(cfg_vs_neg), .cfg_pattern(cfg_pattern), .cfg_solid(cfg_solid),
    .cfg_pending(cfg_pending), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic hs, vs, de, fs; logic [23:0] rgb; } out_t;
  typedef struct { int ht, hs, hst, hen, vt, vs, vst, ven; bit hneg, vneg; int pat; int solid; } mcfg_t;

  out_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [23:0] bars [8];

  // reference model state: position, active/shadow timing, pending flag, scroll offset
  mcfg_t act, shd, nxt;
  int    mh, mv, off;
  bit    pend;

  // frame statistics measured on the outputs
  int st_cnt = 0, st_de = 0, st_hs = 0;
  int per_last = 0, de_last = 0, hs_last = 0;

  function automatic mcfg_t def_cfg();
    mcfg_t c;
    c = '{ht: P_HT, hs: P_HS, hst: P_HST, hen: P_HEN, vt: P_VT, vs: P_VS, vst: P_VST, ven: P_VEN,
          hneg: 1'b0, vneg: 1'b0, pat: 0, solid: 0};
    return c;
  endfunction

  function automatic out_t expect_px(int h, int v, mcfg_t c, int o);
    out_t e;
    int x, y, w, xs;
    logic [7:0] ramp;
    e = '0;
    e.hs = (h <= c.hs) ^ c.hneg;
    e.vs = (v <= c.vs) ^ c.vneg;
    e.fs = (h == 0) && (v == 0);
    e.de = (h > c.hst) && (h <= c.hen) && (v > c.vst) && (v <= c.ven);
    if (e.de) begin
      x = (h - c.hst - 1) & 4095;
      y = (v - c.vst - 1) & 4095;
      case (c.pat)
        0: begin
          w  = c.hen - c.hst;
          xs = SCROLL ? (x + o) % w : x;
          e.rgb = bars[(xs * 8) / w];
        end
        1: begin
          ramp = 8'(x >> 4);
          e.rgb = {ramp, ramp, ramp};
        end
        2: begin
          xs = SCROLL ? (x + o) & 4095 : x;
          e.rgb = ((((xs >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        end
        default: e.rgb = 24'(c.solid);
      endcase
    end
    return e;
  endfunction

  task automatic model_clock(input bit rst_i, input bit load_i);
    bit line_end, frame_end;
    if (rst_i) begin
      mh = 0; mv = 0; act = def_cfg(); shd = '{default: 0}; pend = 1'b0; off = 0;
    end else begin
      line_end  = (mh >= act.ht);
      frame_end = line_end && (mv >= act.vt);
      if (line_end) begin
        mh = 0;
        mv = (mv >= act.vt) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      if (frame_end) begin
        if (pend) act = shd;
        pend = 1'b0;
        off  = (off + 1) & 4095;
      end
      if (load_i) begin
        shd  = nxt;
        pend = 1'b1;
      end
    end
  endtask

  task automatic drive_cfg();
    cfg_h_total = CW'(nxt.ht);  cfg_h_sync  = CW'(nxt.hs);
    cfg_h_start = CW'(nxt.hst); cfg_h_end   = CW'(nxt.hen);
    cfg_v_total = CW'(nxt.vt);  cfg_v_sync  = CW'(nxt.vs);
    cfg_v_start = CW'(nxt.vst); cfg_v_end   = CW'(nxt.ven);
    cfg_hs_neg  = nxt.hneg;     cfg_vs_neg  = nxt.vneg;
    cfg_pattern = 2'(nxt.pat);  cfg_solid   = 24'(nxt.solid);
  endtask

  // one pixel clock: check pending, drive inputs, push the expected output for this counter state
  task automatic step(input bit rst_i, input bit load_i);
    @(negedge clk);
    n_cmp++;
    if (cfg_pending !== pend) begin
      n_bad++;
      $display("FAIL cfg_pending t=%0t got %0b required %0b", $time, cfg_pending, pend);
    end
    reset    = rst_i;
    cfg_load = load_i;
    drive_cfg();
    if (rst_i) foreach (exp_q[i]) exp_q[i] = '0;
    exp_q.push_back(rst_i ? out_t'(0) : expect_px(mh, mv, act, off));
    model_clock(rst_i, load_i);
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s wait budget expired", name);
  endtask

  task automatic wait_apply(input string name);
    int n;
    n = 0;
    while (pend && n < 6000) begin step(1'b0, 1'b0); n++; end
    if (pend) bound_fail(name);
  endtask

  task automatic wait_pos(input int h, input int v, input string name);
    int n;
    n = 0;
    while (!(mh == h && mv == v) && n < 6000) begin step(1'b0, 1'b0); n++; end
    if (!(mh == h && mv == v)) bound_fail(name);
  endtask

  task automatic rand_cfg();
    nxt.ht    = $urandom_range(80, 20);
    nxt.hs    = $urandom_range(5, 0);
    nxt.hst   = $urandom_range(12, nxt.hs + 1);
    nxt.hen   = $urandom_range(nxt.ht, nxt.hst + 8);
    nxt.vt    = $urandom_range(12, 4);
    nxt.vs    = $urandom_range(1, 0);
    nxt.vst   = $urandom_range(2, nxt.vs);
    nxt.ven   = $urandom_range(nxt.vt, nxt.vst + 1);
    nxt.hneg  = 1'($urandom_range(1, 0));
    nxt.vneg  = 1'($urandom_range(1, 0));
    nxt.pat   = $urandom_range(3, 0);
    nxt.solid = int'($urandom & 32'h00FF_FFFF);
  endtask

  function automatic mcfg_t small_cfg();
    mcfg_t c;
    c = '{ht: 9, hs: 1, hst: 3, hen: 7, vt: 5, vs: 0, vst: 1, ven: 4,
          hneg: 1'b0, vneg: 1'b0, pat: 0, solid: 0};
    return c;
  endfunction

  // monitor: pops the expectation for each output cycle and gathers per-frame statistics
  initial begin : monitor
    out_t e, a;
    forever begin
      @(posedge clk);
      #1;
      a = {vid_hs, vid_vs, vid_de, frame_start, vid_r, vid_g, vid_b};
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL pixel t=%0t got hs=%0b vs=%0b de=%0b fs=%0b rgb=%06h required hs=%0b vs=%0b de=%0b fs=%0b rgb=%06h",
                   $time, a.hs, a.vs, a.de, a.fs, a.rgb, e.hs, e.vs, e.de, e.fs, e.rgb);
        end
      end
      if (frame_start === 1'b1) begin
        per_last = st_cnt; de_last = st_de; hs_last = st_hs;
        st_cnt = 0; st_de = 0; st_hs = 0;
      end
      st_cnt++;
      if (vid_de === 1'b1) st_de++;
      if (vid_hs === 1'b1) st_hs++;
    end
  end

  initial begin : driver
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    nxt = def_cfg();
    drive_cfg();
    model_clock(1'b1, 1'b0);
    #1 reset = 1'b1;
    repeat (3) step(1'b1, 1'b0);
    repeat (600) step(1'b0, 1'b0);
    check_int("reset_frame_period", per_last, 480);

    // small timing: 10x6 clk frame
    nxt = small_cfg();
    step(1'b0, 1'b1);
    wait_apply("small_apply");
    repeat (130) step(1'b0, 1'b0);
    check_int("small_frame_period", per_last, 60);
    check_int("small_de_per_frame", de_last, 12);
    check_int("small_hs_per_frame", hs_last, 12);

    // latency: state (4,2) produces de=1 and solid colour exactly 2 clk later
    nxt.pat = 3; nxt.solid = 24'h123456;
    step(1'b0, 1'b1);
    wait_apply("solid_apply");
    wait_pos(4, 2, "lat_wait");
    step(1'b0, 1'b0);
    @(posedge clk); #1;
    check_int("lat_de_at_1clk", int'(vid_de), 0);
    step(1'b0, 1'b0);
    @(posedge clk); #1;
    check_int("lat_de_at_2clk", int'(vid_de), 1);
    check_int("lat_rgb", int'({vid_r, vid_g, vid_b}), 32'h123456);

    // mid-frame load flipping hsync polarity
    nxt.hneg = 1'b1; nxt.pat = 2;
    wait_pos(5, 3, "mid_wait");
    step(1'b0, 1'b1);
    wait_apply("neg_apply");
    repeat (130) step(1'b0, 1'b0);
    check_int("neg_hs_high_per_frame", hs_last, 48);
    check_int("neg_frame_period", per_last, 60);

    // long lines, then shrink while h_cnt = 500
    nxt = '{ht: 799, hs: 10, hst: 20, hen: 700, vt: 2, vs: 0, vst: 0, ven: 2,
            hneg: 1'b0, vneg: 1'b0, pat: 0, solid: 0};
    step(1'b0, 1'b1);
    wait_apply("long_apply");
    wait_pos(500, 1, "shrink_wait");
    nxt.ht = 99; nxt.hen = 90;
    step(1'b0, 1'b1);
    wait_apply("shrink_apply");
    repeat (700) step(1'b0, 1'b0);
    check_int("shrink_frame_period", per_last, 300);

    // random configurations: repeated loads and a load on the apply cycle
    for (int i = 0; i < 8; i++) begin
      rand_cfg();
      repeat ($urandom_range(150, 0)) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      if ($urandom_range(1, 0) == 1) begin
        rand_cfg();
        repeat ($urandom_range(20, 1)) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
      end
      if (i == 3) begin
        for (int n = 0; n < 6000 && !(mh >= act.ht && mv >= act.vt); n++) step(1'b0, 1'b0);
        rand_cfg();
        step(1'b0, 1'b1);
        check_int("coincident_load_keeps_pending", int'(cfg_pending), 1);
      end
      wait_apply("rand_apply");
      repeat ($urandom_range(300, 100)) step(1'b0, 1'b0);
    end

    // reset mid-line with a load pending: parameter timing resumes
    rand_cfg();
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    repeat (1000) step(1'b0, 1'b0);
    check_int("post_reset_frame_period", per_last, 480);
    check_int("post_reset_hs_per_frame", hs_last, 48);
    check_int("post_reset_de_per_frame", de_last, 224);

    repeat (3) step(1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
